// File: rtl/secure_key_pkg.sv
// rtl/secure_key_pkg.sv - shared state encoding and counter widths for secure_key_tx
//
// Purpose: FSM state type used by the key transmitter, plus the widths of its
//          internal bit-index and repeat counters.
// Ports:   none (package).
package secure_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_CNT  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Bit index must reach KEY_W-1 (up to 31), CNT_W-1 and GAP-1.
    localparam int IDX_W = 6;
    // Repeat count must reach REPEAT-1 (up to 14).
    localparam int REP_W = 4;

endpackage

// File: rtl/secure_key_tx_rolling_counter.sv
// rtl/secure_key_tx_rolling_counter.sv - wrapping rolling-code counter
//
// Purpose: CNT_W-bit counter that advances by one on inc and wraps from
//          all-ones to zero; clear has priority over inc.
// Ports:   clk   - clock
//          reset - asynchronous active-low reset (value -> 0)
//          inc   - advance by one this edge
//          clear - force to zero this edge
//          value - current count
module rolling_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/secure_key_tx.sv
// rtl/secure_key_tx.sv - serial fixed-key plus rolling-code frame transmitter
//
// Purpose: on trigger A, sends REPEAT frames of {KEY, counter} MSB first, one
//          bit per cycle, with GAP idle cycles between frames; pulses done and
//          advances the rolling counter after the last frame.
// Ports:   clk     - clock
//          reset   - asynchronous active-low reset
//          A       - trigger level, sampled only in IDLE
//          cancel  - synchronous abort (also blocks a trigger in IDLE)
//          R       - serial frame bit
//          R_valid - high while R carries a frame bit
//          busy    - high whenever not IDLE
//          done    - one-cycle pulse after normal completion
//          code    - current rolling-counter value
module secure_key_tx
    import secure_key_pkg::*;
#(
    parameter int               KEY_W  = 4,
    parameter logic [KEY_W-1:0] KEY    = 4'b1101,
    parameter int               CNT_W  = 8,
    parameter int               REPEAT = 1,
    parameter int               GAP    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             cancel,
    output logic             R,
    output logic             R_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] code
);

    localparam int SW = KEY_W + CNT_W;

    localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_W - 1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(CNT_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [REP_W-1:0] rep;
    logic [SW-1:0]    sreg;
    logic [CNT_W-1:0] cap;
    logic             done_r;
    logic             inc;

    // The counter advances on the same edge that leaves the last counter bit
    // of the last frame, so code already shows the new value while done is high.
    assign inc = (state == ST_CNT) && !cancel && (idx == CNT_LAST) && (rep == REP_LAST);

    rolling_counter #(
        .CNT_W (CNT_W)
    ) u_rolling_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .clear (1'b0),
        .value (code)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            rep    <= '0;
            sreg   <= '0;
            cap    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cancel && A) begin
                        state <= ST_KEY;
                        idx   <= '0;
                        rep   <= '0;
                        sreg  <= {KEY, code};
                        cap   <= code;
                    end
                end
                ST_KEY: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        sreg <= {sreg[SW-2:0], 1'b0};
                        if (idx == KEY_LAST) begin
                            state <= ST_CNT;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_CNT: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        sreg <= {sreg[SW-2:0], 1'b0};
                        if (idx == CNT_LAST) begin
                            idx <= '0;
                            if (rep == REP_LAST) begin
                                state  <= ST_IDLE;
                                done_r <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                                rep   <= rep + REP_W'(1);
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (idx == GAP_LAST) begin
                        // Every repeat re-sends the code captured at the trigger.
                        state <= ST_KEY;
                        idx   <= '0;
                        sreg  <= {KEY, cap};
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from registers only; the frame bit is always the shifter MSB.
    assign busy    = (state != ST_IDLE);
    assign R_valid = (state == ST_KEY) || (state == ST_CNT);
    assign R       = R_valid & sreg[SW-1];
    assign done    = done_r;

endmodule

// File: tb/tb_secure_key_tx.sv
// tb/tb_secure_key_tx.sv - directed self-checking bench for secure_key_tx
module tb_secure_key_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: defaults
    logic       A0, cancel0, R0, V0, busy0, done0;
    logic [7:0] code0;
    // dut1: REPEAT=3, GAP=2
    logic       A1, cancel1, R1, V1, busy1, done1;
    logic [7:0] code1;
    // dut2: CNT_W=4
    logic       A2, cancel2, R2, V2, busy2, done2;
    logic [3:0] code2;

    secure_key_tx dut0 (
        .clk(clk), .reset(reset), .A(A0), .cancel(cancel0),
        .R(R0), .R_valid(V0), .busy(busy0), .done(done0), .code(code0)
    );

    secure_key_tx #(.REPEAT(3), .GAP(2)) dut1 (
        .clk(clk), .reset(reset), .A(A1), .cancel(cancel1),
        .R(R1), .R_valid(V1), .busy(busy1), .done(done1), .code(code1)
    );

    secure_key_tx #(.CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .A(A2), .cancel(cancel2),
        .R(R2), .R_valid(V2), .busy(busy2), .done(done2), .code(code2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        A0 = 0; A1 = 0; A2 = 0;
        cancel0 = 0; cancel1 = 0; cancel2 = 0;
        tick;
        tick;
        n_checks++;
        if ({R0, V0, busy0, done0, code0} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset dut0: R=%b valid=%b busy=%b done=%b code=%0d, expected all 0", R0, V0, busy0, done0, code0);
        end
        n_checks++;
        if ({R1, V1, busy1, done1, code1, R2, V2, busy2, done2, code2} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset dut1/dut2: outputs=%h, expected 0", {R1, V1, busy1, done1, code1, R2, V2, busy2, done2, code2});
        end
        reset = 1'b1;
        tick;
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b, expected 0", busy0);
        end
    endtask

    task automatic test_single_frame;
        logic [11:0] fr;
        fr = {4'b1101, 8'h00};
        A0 = 1; tick; A0 = 0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (R0 !== fr[11-i] || V0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL single_frame bit %0d: R=%b valid=%b busy=%b done=%b, expected R=%b valid=1 busy=1 done=0", i, R0, V0, busy0, done0, fr[11-i]);
            end
            tick;
        end
        n_checks++;
        if (done0 !== 1'b1 || V0 !== 1'b0 || busy0 !== 1'b0 || code0 !== 8'd1 || R0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frame end: done=%b valid=%b busy=%b R=%b code=%0d, expected done=1 valid=0 busy=0 R=0 code=1", done0, V0, busy0, R0, code0);
        end
        tick;
        n_checks++;
        if (done0 !== 1'b0 || code0 !== 8'd1) begin
            n_fail++;
            $display("FAIL single_frame done_pulse: done=%b code=%0d, expected done=0 code=1", done0, code0);
        end
    endtask

    task automatic test_repeat;
        logic [11:0] fr;
        int          pos;
        int          ndone;
        logic        er, ev;
        fr = {4'b1101, 8'h00};
        ndone = 0;
        A1 = 1; tick; A1 = 0;
        for (int c = 0; c < 40; c++) begin
            pos = c % 14;
            ev  = (pos < 12);
            er  = ev ? fr[11-pos] : 1'b0;
            n_checks++;
            if (R1 !== er || V1 !== ev || busy1 !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat cycle %0d: R=%b valid=%b busy=%b, expected R=%b valid=%b busy=1", c, R1, V1, busy1, er, ev);
            end
            if (done1 === 1'b1) ndone++;
            tick;
        end
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b1 || code1 !== 8'd1 || ndone != 0) begin
            n_fail++;
            $display("FAIL repeat end: busy=%b done=%b code=%0d early_done=%0d, expected busy=0 done=1 code=1 early_done=0", busy1, done1, code1, ndone);
        end
        tick;
        n_checks++;
        if (done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat done_pulse: done=%b, expected 0", done1);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] fr;
        logic [3:0] kv;
        logic [3:0] nv;
        for (int k = 0; k < 17; k++) begin
            kv = 4'(k);
            nv = 4'(k + 1);
            fr = {4'b1101, kv};
            A2 = 1; tick; A2 = 0;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (R2 !== fr[7-i] || V2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap frame %0d bit %0d: R=%b valid=%b, expected R=%b valid=1", k, i, R2, V2, fr[7-i]);
                end
                tick;
            end
            n_checks++;
            if (done2 !== 1'b1 || code2 !== nv) begin
                n_fail++;
                $display("FAIL wrap code after frame %0d: done=%b code=%0d, expected done=1 code=%0d", k, done2, code2, nv);
            end
        end
    endtask

    task automatic test_cancel;
        logic [11:0] fr;
        A0 = 1; tick; A0 = 0;
        tick;
        tick;
        n_checks++;
        if (R0 !== 1'b0 || V0 !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel third_key_bit: R=%b valid=%b, expected R=0 valid=1", R0, V0);
        end
        cancel0 = 1; tick; cancel0 = 0;
        n_checks++;
        if (busy0 !== 1'b0 || V0 !== 1'b0 || R0 !== 1'b0 || done0 !== 1'b0 || code0 !== 8'd1) begin
            n_fail++;
            $display("FAIL cancel abort: busy=%b valid=%b R=%b done=%b code=%0d, expected 0 0 0 0 code=1", busy0, V0, R0, done0, code0);
        end
        tick;
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || code0 !== 8'd1) begin
            n_fail++;
            $display("FAIL cancel no_done: done=%b busy=%b code=%0d, expected done=0 busy=0 code=1", done0, busy0, code0);
        end
        A0 = 1; cancel0 = 1; tick; A0 = 0; cancel0 = 0;
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel idle_priority: busy=%b, expected 0", busy0);
        end
        fr = {4'b1101, 8'h01};
        A0 = 1; tick; A0 = 0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (R0 !== fr[11-i] || V0 !== 1'b1) begin
                n_fail++;
                $display("FAIL cancel restart bit %0d: R=%b valid=%b, expected R=%b valid=1", i, R0, V0, fr[11-i]);
            end
            tick;
        end
        n_checks++;
        if (done0 !== 1'b1 || code0 !== 8'd2) begin
            n_fail++;
            $display("FAIL cancel restart_end: done=%b code=%0d, expected done=1 code=2", done0, code0);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [11:0] fr;
        logic [7:0]  cv;
        A0 = 1; tick;
        for (int f = 0; f < 3; f++) begin
            cv = 8'(2 + f);
            fr = {4'b1101, cv};
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (R0 !== fr[11-i] || V0 !== 1'b1 || busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back frame %0d bit %0d: R=%b valid=%b busy=%b, expected R=%b valid=1 busy=1", f, i, R0, V0, busy0, fr[11-i]);
                end
                if (i == 4) A0 = 0;
                if (i == 7) A0 = 1;
                tick;
            end
            n_checks++;
            if (done0 !== 1'b1 || busy0 !== 1'b0 || code0 !== 8'(3 + f)) begin
                n_fail++;
                $display("FAIL back_to_back end %0d: done=%b busy=%b code=%0d, expected done=1 busy=0 code=%0d", f, done0, busy0, code0, 3 + f);
            end
            if (f == 2) A0 = 0;
            tick;
        end
        n_checks++;
        if (busy0 !== 1'b0 || code0 !== 8'd5) begin
            n_fail++;
            $display("FAIL back_to_back stop: busy=%b code=%0d, expected busy=0 code=5", busy0, code0);
        end
    endtask

    task automatic test_async_reset;
        logic [11:0] fr;
        A0 = 1; tick; A0 = 0;
        repeat (6) tick;
        n_checks++;
        if (V0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset in_cnt: valid=%b busy=%b, expected 1 1", V0, busy0);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({R0, V0, busy0, done0} !== 4'b0000 || code0 !== 8'd0 || code1 !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset immediate: R=%b valid=%b busy=%b done=%b code=%0d, expected all 0", R0, V0, busy0, done0, code0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        tick;
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset after: busy=%b done=%b, expected 0 0", busy0, done0);
        end
        fr = {4'b1101, 8'h00};
        A0 = 1; tick; A0 = 0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (R0 !== fr[11-i] || V0 !== 1'b1) begin
                n_fail++;
                $display("FAIL async_reset refire bit %0d: R=%b valid=%b, expected R=%b valid=1", i, R0, V0, fr[11-i]);
            end
            tick;
        end
        n_checks++;
        if (done0 !== 1'b1 || code0 !== 8'd1) begin
            n_fail++;
            $display("FAIL async_reset refire_end: done=%b code=%0d, expected done=1 code=1", done0, code0);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_repeat;
        test_wrap;
        test_cancel;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/secure_key_tx.md
SECURE_KEY_TX -- requirements
Module: secure_key_tx

Interface
REQ-001 The block SHALL have parameter KEY_W, default 4, meaning fixed-key length in bits (range 2..32).
REQ-002 The block SHALL have parameter KEY, default 4'b1101, meaning the fixed key value, KEY_W bits wide, transmitted MSB first.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning rolling-code counter width in bits (range 1..16).
REQ-004 The block SHALL have parameter REPEAT, default 1, meaning frames sent per trigger (range 1..15).
REQ-005 The block SHALL have parameter GAP, default 2, meaning idle cycles between repeated frames (range 1..15).
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-008 Port A, input, 1 bit, SHALL be the trigger: a level sampled only in IDLE.
REQ-009 Port cancel, input, 1 bit, SHALL be a synchronous abort request.
REQ-010 Port R, output, 1 bit, SHALL be the serial key/code bit.
REQ-011 Port R_valid, output, 1 bit, SHALL be high exactly on cycles where R carries a frame bit.
REQ-012 Port busy, output, 1 bit, SHALL be high whenever state is not IDLE.
REQ-013 Port done, output, 1 bit, SHALL be a one-cycle pulse on normal completion of all repeats.
REQ-014 Port code, output, CNT_W bits, SHALL be the current rolling-counter value.

Function
REQ-015 The FSM SHALL have states IDLE, KEY, CNT and GAP.
REQ-016 In IDLE, A=1 at a clock edge SHALL move to KEY and clear the bit index and repeat count; A=0 SHALL stay in IDLE.
REQ-017 A frame SHALL be KEY_W key bits followed by CNT_W counter bits, both MSB first, one bit per cycle, with no gap between key and counter fields.
REQ-018 The first key bit SHALL appear on R, with R_valid=1, in the cycle immediately after the edge that sampled A=1 (latency 1).
REQ-019 After the last key bit, the FSM SHALL go KEY->CNT; after the last counter bit it SHALL go to GAP if frames remain, else to IDLE.
REQ-020 GAP SHALL last exactly GAP cycles with R=0 and R_valid=0, then return to KEY.
REQ-021 All REPEAT frames of one trigger SHALL carry the same counter value, captured on entry to the first KEY.
REQ-022 done SHALL pulse in the first IDLE cycle after the last counter bit of the last frame; in that same edge the counter SHALL increment by 1, modulo 2^CNT_W (all-ones wraps to 0).
REQ-023 While busy, A SHALL be ignored, and a held A SHALL not retrigger until the FSM is back in IDLE.
REQ-024 A held A SHALL retrigger on the first IDLE edge: the first IDLE cycle after completion, while done is high.
REQ-025 cancel=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse and no counter increment.
REQ-026 cancel=1 in IDLE SHALL have priority over A.
REQ-027 In IDLE, R SHALL be 0 and R_valid SHALL be 0.
REQ-028 Outputs SHALL be decoded from registered state and index only, with no combinational path from A or cancel to any output.

Reset
REQ-029 reset=0 SHALL asynchronously force state=IDLE, the bit index, repeat count and captured code to 0, the counter to 0, and R=0, R_valid=0, busy=0, done=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse, and counter progress SHALL be lost.
REQ-031 Deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-032 The state encoding constants (IDLE=0, KEY=1, CNT=2, GAP=3, 2 bits) SHALL live in a shared package secure_key_pkg.
REQ-033 The rolling counter SHALL be one sub-module, rolling_counter, parametrised by CNT_W, with inc and clear inputs and a value output.
REQ-034 The frame shifter SHALL be a single shift register of width KEY_W+CNT_W, loaded on the trigger edge.

Verification
REQ-035 Defaults, A=1 for one cycle after reset -> R = 1,1,0,1,0,0,0,0,0,0,0,0 on 12 consecutive cycles with R_valid=1, then done pulses once and code becomes 1.
REQ-036 REPEAT=3, GAP=2, A pulse -> three identical 12-bit frames separated by 2 cycles of R_valid=0, busy high for 40 cycles, and one done pulse.
REQ-037 CNT_W=4, 16 triggers -> code counts 1..15 then wraps to 0, and the 17th frame carries counter bits 0000.
REQ-038 cancel asserted during the 3rd key bit -> IDLE next cycle, no done pulse, code unchanged, and a new A restarts from key bit 0.
REQ-039 reset=0 asynchronously mid CNT field -> all outputs 0 immediately without waiting for clk, and code=0.
REQ-040 A held high continuously -> back-to-back triggers, each new frame starting the cycle after done, and A toggling during busy has no effect.
